issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter MD_LAT, default 8, mul/div/rem occupancy in cycles, legal range 2..63.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports id_valid in 1 and id_rs1 / id_rs2 / id_rd in 5 each: ID-stage valid flag and register fields from decoder.
REQ-005 SHALL have ports id_use_rs1 / id_use_rs2 in 1 each: the instruction reads that source.
REQ-006 SHALL have ports id_reg_w, id_mem_r, id_branch in 1 each: decoder control bits.
REQ-007 SHALL have port id_instr_id in 7: decoder instruction ID.
REQ-008 SHALL have ports ex_redirect in 1 (taken branch/jump resolved in EX), wb_valid in 1 and wb_rd in 5 (retiring write).
REQ-009 SHALL have outputs issue, stall, bubble, flush and md_busy, each 1 bit: ID->EX advance, hold PC and IF/ID, force EX opcode 0, squash IF/ID, mul/div unit occupied.

Function
REQ-010 SHALL keep a 32-entry pending-write scoreboard; entry 0 SHALL always read 0.
REQ-011 hazard SHALL be (id_use_rs1 & pending[id_rs1]) | (id_use_rs2 & pending[id_rs2]); source x0 never hazards.
REQ-012 md_hit SHALL be id_instr_id in {mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw}.
REQ-013 issue SHALL be id_valid & ~hazard & ~md_busy & ~ex_redirect & ~rst; all outputs combinational from inputs plus registered state.
REQ-014 stall SHALL be id_valid & ~issue & ~ex_redirect; bubble SHALL be ~issue; flush SHALL equal ex_redirect.
REQ-015 On issue with id_reg_w and id_rd != 0, pending[id_rd] SHALL set next cycle.
REQ-016 On wb_valid with wb_rd != 0, pending[wb_rd] SHALL clear next cycle; on same-cycle set and clear of one index, set SHALL win.
REQ-017 A load (id_mem_r) SHALL use the same scoreboard; no forwarding assumed, so a dependent instruction stalls until the load's WB.
REQ-018 FSM states: RUN, MD_WAIT; RUN->MD_WAIT on issue & md_hit, loading counter with MD_LAT-1.
REQ-019 In MD_WAIT the counter SHALL decrement each cycle; at counter==0, next state RUN; md_busy SHALL be 1 exactly in MD_WAIT, MD_LAT-1 cycles.
REQ-020 ex_redirect SHALL NOT abort MD_WAIT nor clear pending entries (redirecting instruction is older, already issued).
REQ-021 id_valid=0 SHALL yield issue=0, stall=0, bubble=1 with no scoreboard set.
REQ-022 Counter width SHALL be 6 bits; no wrap below 0.

Reset
REQ-023 rst SHALL clear all pending entries, counter to 0, state to RUN, synchronously.
REQ-024 While rst=1 outputs SHALL be issue=0, stall=0, bubble=1, flush=ex_redirect, md_busy=0; rst mid-MD_WAIT SHALL abandon the wait.

Structure
REQ-025 FSM encoding and MD_LAT default SHALL live in shared package ctrl_pkg; instr_id codes SHALL come from the existing shared instruction definitions, not be redefined.
REQ-026 Scoreboard SHALL be sub-module scoreboard (set port, clear port, two read ports); FSM/counter and output logic stay in issue_ctrl.

Verification
REQ-027 addi x5 issued, next ID add x6,x5,x1 use_rs1 -> stall=1, bubble=1 until wb_valid wb_rd=5, issue=1 the following cycle.
REQ-028 mul x7 issued with MD_LAT=8 -> md_busy=1 for 7 cycles, next id_valid instruction stalls 7 cycles then issue=1.
REQ-029 ex_redirect=1 with id_valid=1, no hazard -> flush=1, issue=0, stall=0, bubble=1, scoreboard unchanged.
REQ-030 Same cycle: issue writing x9 and wb_valid wb_rd=9 -> pending[9]=1 after edge.
REQ-031 ID reads x0 with wb pending writes elsewhere, id_rd=0 with reg_w -> no stall, pending[0] stays 0.
REQ-032 rst asserted 3 cycles into MD_WAIT -> next cycle state RUN, md_busy=0, all pending 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Issue-control shared definitions: FSM encoding, mul/div latency default
// and mul/div instruction classification.
package ctrl_pkg;

    import instr_pkg::*;

    localparam int unsigned MD_LAT_DEFAULT = 8;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_WAIT = 1'b1
    } issue_state_e;

    // True for every instruction that occupies the multi-cycle mul/div unit
    function automatic logic is_md_instr(input logic [6:0] id);
        return id inside {ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU,
                          ID_DIV, ID_DIVU, ID_REM, ID_REMU,
                          ID_MULW, ID_DIVW, ID_DIVUW, ID_REMW, ID_REMUW};
    endfunction

endpackage

// File: rtl/instr_pkg.sv
// Shared instruction ID codes produced by the decoder.
package instr_pkg;

    localparam logic [6:0] ID_NOP    = 7'd0;
    localparam logic [6:0] ID_ADD    = 7'd1;
    localparam logic [6:0] ID_SUB    = 7'd2;
    localparam logic [6:0] ID_ADDI   = 7'd3;
    localparam logic [6:0] ID_LW     = 7'd4;
    localparam logic [6:0] ID_SW     = 7'd5;
    localparam logic [6:0] ID_BEQ    = 7'd6;
    localparam logic [6:0] ID_JAL    = 7'd7;
    localparam logic [6:0] ID_ADDW   = 7'd19;
    localparam logic [6:0] ID_MUL    = 7'd20;
    localparam logic [6:0] ID_MULH   = 7'd21;
    localparam logic [6:0] ID_MULHSU = 7'd22;
    localparam logic [6:0] ID_MULHU  = 7'd23;
    localparam logic [6:0] ID_DIV    = 7'd24;
    localparam logic [6:0] ID_DIVU   = 7'd25;
    localparam logic [6:0] ID_REM    = 7'd26;
    localparam logic [6:0] ID_REMU   = 7'd27;
    localparam logic [6:0] ID_MULW   = 7'd28;
    localparam logic [6:0] ID_DIVW   = 7'd29;
    localparam logic [6:0] ID_DIVUW  = 7'd30;
    localparam logic [6:0] ID_REMW   = 7'd31;
    localparam logic [6:0] ID_REMUW  = 7'd32;
    localparam logic [6:0] ID_SLLW   = 7'd33;

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// 32-entry pending-write scoreboard: one set port, one clear port, two
// read ports. Entry 0 (x0) can never become pending.
module scoreboard (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_set_en,
    input  logic [4:0] i_set_idx,
    input  logic       i_clr_en,
    input  logic [4:0] i_clr_idx,
    input  logic [4:0] i_rd_idx_a,
    input  logic [4:0] i_rd_idx_b,
    output logic       o_rd_a,
    output logic       o_rd_b
);

    logic [31:0] r_pending;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;

    // Decode set/clear indices into one-hot masks; x0 is never set
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en) begin
            w_set_mask[i_set_idx] = 1'b1;
        end
        if (i_clr_en) begin
            w_clr_mask[i_clr_idx] = 1'b1;
        end
        w_set_mask[0] = 1'b0;
    end

    // Clear first, then set, so a same-cycle set of the same index wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
        end
    end

    assign o_rd_a = r_pending[i_rd_idx_a];
    assign o_rd_b = r_pending[i_rd_idx_b];

endmodule

// File: rtl/issue_ctrl.sv
// ID->EX issue control: scoreboard hazard detection, mul/div occupancy
// FSM and pipeline stall/bubble/flush generation.
module issue_ctrl
    import ctrl_pkg::*;
#(
    parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic [4:0] id_rd,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       id_reg_w,
    input  logic       id_mem_r,
    input  logic       id_branch,
    input  logic [6:0] id_instr_id,
    input  logic       ex_redirect,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
    output logic       issue,
    output logic       stall,
    output logic       bubble,
    output logic       flush,
    output logic       md_busy
);

    localparam logic [5:0] MD_LOAD = 6'(MD_LAT - 1);

    issue_state_e r_state;
    logic [5:0]   r_md_cnt;

    logic w_pend_rs1;
    logic w_pend_rs2;
    logic w_hazard;
    logic w_md_hit;
    logic w_md_busy;
    logic w_issue;
    logic w_sb_set;
    logic w_sb_clr;
    logic w_unused;

    // Loads share the scoreboard with ALU writes; the memory/branch flags
    // carry no extra issue rule here
    assign w_unused = id_mem_r ^ id_branch;

    scoreboard u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (w_sb_set),
        .i_set_idx  (id_rd),
        .i_clr_en   (w_sb_clr),
        .i_clr_idx  (wb_rd),
        .i_rd_idx_a (id_rs1),
        .i_rd_idx_b (id_rs2),
        .o_rd_a     (w_pend_rs1),
        .o_rd_b     (w_pend_rs2)
    );

    assign w_hazard  = (id_use_rs1 & w_pend_rs1) | (id_use_rs2 & w_pend_rs2);
    assign w_md_hit  = is_md_instr(id_instr_id);
    assign w_md_busy = (r_state == ST_MD_WAIT) & ~rst;
    assign w_issue   = id_valid & ~w_hazard & ~w_md_busy & ~ex_redirect & ~rst;
    assign w_sb_set  = w_issue & id_reg_w & (id_rd != 5'd0);
    assign w_sb_clr  = wb_valid & (wb_rd != 5'd0);

    assign issue   = w_issue;
    assign stall   = id_valid & ~w_issue & ~ex_redirect & ~rst;
    assign bubble  = ~w_issue;
    assign flush   = ex_redirect;
    assign md_busy = w_md_busy;

    // Mul/div occupancy FSM; redirects do not abort a wait, reset does
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_md_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_issue && w_md_hit) begin
                        r_state  <= ST_MD_WAIT;
                        r_md_cnt <= MD_LOAD;
                    end
                end
                ST_MD_WAIT: begin
                    // Leave as the count reaches 0 so the wait lasts MD_LAT-1 cycles
                    if (r_md_cnt <= 6'd1) begin
                        r_md_cnt <= '0;
                        r_state  <= ST_RUN;
                    end else begin
                        r_md_cnt <= r_md_cnt - 6'd1;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_md_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed vector table, hand-written
// mul/div and reset sequences, then randomized traffic against a model.
module tb_issue_ctrl;

    import instr_pkg::*;

    localparam int unsigned MD_LAT = 8;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic       id_reg_w;
    logic       id_mem_r;
    logic       id_branch;
    logic [6:0] id_instr_id;
    logic       ex_redirect;
    logic       wb_valid;
    logic [4:0] wb_rd;
    logic       issue;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       md_busy;

    int total = 0;
    int bad   = 0;

    issue_ctrl #(.MD_LAT(MD_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_reg_w    (id_reg_w),
        .id_mem_r    (id_mem_r),
        .id_branch   (id_branch),
        .id_instr_id (id_instr_id),
        .ex_redirect (ex_redirect),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .issue       (issue),
        .stall       (stall),
        .bubble      (bubble),
        .flush       (flush),
        .md_busy     (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [6:0] md_codes [13] = '{ID_MUL, ID_MULH, ID_MULHSU, ID_MULHU, ID_DIV,
                                  ID_DIVU, ID_REM, ID_REMU, ID_MULW, ID_DIVW,
                                  ID_DIVUW, ID_REMW, ID_REMUW};
    bit [31:0] m_pend      = '0;
    int        m_busy_left = 0;   // upcoming cycles the mul/div unit is occupied

    function automatic bit m_is_md(logic [6:0] id);
        for (int k = 0; k < 13; k++) begin
            if (md_codes[k] == id) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_expect(output bit ei, output bit es, output bit eb,
                                output bit ef, output bit ebusy);
        bit haz;
        ebusy = (m_busy_left > 0) && !rst;
        haz   = (id_use_rs1 && id_rs1 != 5'd0 && m_pend[id_rs1]) ||
                (id_use_rs2 && id_rs2 != 5'd0 && m_pend[id_rs2]);
        ei    = id_valid && !haz && !ebusy && !ex_redirect && !rst;
        es    = id_valid && !ei && !ex_redirect && !rst;
        eb    = !ei;
        ef    = ex_redirect;
    endtask

    task automatic model_update();
        bit ei, es, eb, ef, ebusy;
        model_expect(ei, es, eb, ef, ebusy);
        if (rst) begin
            m_pend      = '0;
            m_busy_left = 0;
        end else begin
            if (m_busy_left > 0) m_busy_left--;
            if (ei && m_is_md(id_instr_id)) m_busy_left = MD_LAT - 1;
            if (wb_valid && wb_rd != 5'd0) m_pend[wb_rd] = 1'b0;
            if (ei && id_reg_w && id_rd != 5'd0) m_pend[id_rd] = 1'b1;
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_outs(string tag, bit ei, bit es, bit eb, bit ef, bit ebusy);
        chk({tag, ".issue"},   issue,   ei);
        chk({tag, ".stall"},   stall,   es);
        chk({tag, ".bubble"},  bubble,  eb);
        chk({tag, ".flush"},   flush,   ef);
        chk({tag, ".md_busy"}, md_busy, ebusy);
    endtask

    // Check outputs mid-cycle, then clock the DUT and the model together
    task automatic cyc_chk(string tag, bit ei, bit es, bit eb, bit ef, bit ebusy);
        @(negedge clk);
        chk_outs(tag, ei, es, eb, ef, ebusy);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(bit r, bit v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          bit u1, bit u2, bit rw, bit mr, logic [6:0] iid,
                          bit redir, bit wbv, logic [4:0] wbrd);
        rst = r; id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_reg_w = rw; id_mem_r = mr;
        id_branch = (iid == ID_BEQ) || (iid == ID_JAL); id_instr_id = iid;
        ex_redirect = redir; wb_valid = wbv; wb_rd = wbrd;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string      name;
        bit         r, v;
        logic [4:0] rs1, rs2, rd;
        bit         u1, u2, rw, mr;
        logic [6:0] iid;
        bit         redir, wbv;
        logic [4:0] wbrd;
        bit         ei, es, eb, ef, ebusy;
        int         pidx;   // scoreboard entry to check after the edge, -1 for none
        bit         pval;
    } vec_t;

    vec_t vecs[$];

    task automatic add(string name, bit r, bit v, logic [4:0] rs1, logic [4:0] rs2,
                       logic [4:0] rd, bit u1, bit u2, bit rw, bit mr, logic [6:0] iid,
                       bit redir, bit wbv, logic [4:0] wbrd,
                       bit ei, bit es, bit eb, bit ef, bit ebusy, int pidx, bit pval);
        vec_t t;
        t.name = name; t.r = r; t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd;
        t.u1 = u1; t.u2 = u2; t.rw = rw; t.mr = mr; t.iid = iid;
        t.redir = redir; t.wbv = wbv; t.wbrd = wbrd;
        t.ei = ei; t.es = es; t.eb = eb; t.ef = ef; t.ebusy = ebusy;
        t.pidx = pidx; t.pval = pval;
        vecs.push_back(t);
    endtask

    initial begin
        logic [31:0] zero32;
        zero32 = '0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        @(posedge clk);
        #1;

        //   name          r v rs1 rs2 rd u1 u2 rw mr iid      rd wb wbrd  is st bu fl mb pidx pval
        add("rst",         1,1, 1,  2, 3, 1, 1, 1, 0, ID_ADD,  0, 0, 0,    0, 0, 1, 0, 0, 3,  0);
        add("rst_redir",   1,1, 1,  2, 3, 1, 1, 1, 0, ID_ADD,  1, 0, 0,    0, 0, 1, 1, 0, 3,  0);
        add("addi_x5",     0,1, 1,  0, 5, 1, 0, 1, 0, ID_ADDI, 0, 0, 0,    1, 0, 0, 0, 0, 5,  1);
        add("raw_x5_a",    0,1, 5,  1, 6, 1, 1, 1, 0, ID_ADD,  0, 0, 0,    0, 1, 1, 0, 0, 6,  0);
        add("raw_x5_b",    0,1, 5,  1, 6, 1, 1, 1, 0, ID_ADD,  0, 0, 0,    0, 1, 1, 0, 0, 5,  1);
        add("raw_x5_wb",   0,1, 5,  1, 6, 1, 1, 1, 0, ID_ADD,  0, 1, 5,    0, 1, 1, 0, 0, 5,  0);
        add("raw_x5_go",   0,1, 5,  1, 6, 1, 1, 1, 0, ID_ADD,  0, 0, 0,    1, 0, 0, 0, 0, 6,  1);
        add("redirect",    0,1, 2,  0, 8, 1, 0, 1, 0, ID_ADD,  1, 0, 0,    0, 0, 1, 1, 0, 8,  0);
        add("set_clr_x9",  0,1, 1,  0, 9, 1, 0, 1, 0, ID_ADDI, 0, 1, 9,    1, 0, 0, 0, 0, 9,  1);
        add("x0_reads",    0,1, 0,  0, 0, 1, 1, 1, 0, ID_ADD,  0, 1, 6,    1, 0, 0, 0, 0, 0,  0);
        add("x6_cleared",  0,0, 0,  0, 0, 0, 0, 0, 0, ID_NOP,  0, 0, 0,    0, 0, 1, 0, 0, 6,  0);
        add("idle_rw",     0,0, 1,  0,10, 1, 0, 1, 0, ID_ADDI, 0, 0, 0,    0, 0, 1, 0, 0, 10, 0);
        add("rs2_unused",  0,1, 1,  9,11, 1, 0, 1, 0, ID_ADDI, 0, 0, 0,    1, 0, 0, 0, 0, 11, 1);
        add("rs2_used",    0,1, 1,  9,12, 1, 1, 1, 0, ID_ADD,  0, 0, 0,    0, 1, 1, 0, 0, 12, 0);
        add("load_x13",    0,1, 1,  0,13, 1, 0, 1, 1, ID_LW,   0, 0, 0,    1, 0, 0, 0, 0, 13, 1);
        add("load_use_a",  0,1,13,  0,14, 1, 0, 1, 0, ID_ADD,  0, 0, 0,    0, 1, 1, 0, 0, 14, 0);
        add("load_use_wb", 0,1,13,  0,14, 1, 0, 1, 0, ID_ADD,  0, 1,13,    0, 1, 1, 0, 0, 13, 0);
        add("load_use_go", 0,1,13,  0,14, 1, 0, 1, 0, ID_ADD,  0, 0, 0,    1, 0, 0, 0, 0, 14, 1);

        foreach (vecs[i]) begin
            set_in(vecs[i].r, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].u1, vecs[i].u2, vecs[i].rw, vecs[i].mr, vecs[i].iid,
                   vecs[i].redir, vecs[i].wbv, vecs[i].wbrd);
            cyc_chk(vecs[i].name, vecs[i].ei, vecs[i].es, vecs[i].eb, vecs[i].ef, vecs[i].ebusy);
            if (vecs[i].pidx >= 0) begin
                chk({vecs[i].name, ".pending"}, dut.u_sb.r_pending[vecs[i].pidx], vecs[i].pval);
            end
        end

        // ---------- mul occupancy, non-md neighbours, redirect inside the wait ----------
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        cyc_chk("md_rst", 0, 0, 1, 0, 0);
        set_in(0, 1, 1, 2, 7, 1, 1, 1, 0, ID_MUL, 0, 0, 0);
        cyc_chk("mul_issue", 1, 0, 0, 0, 0);
        set_in(0, 1, 3, 4, 20, 1, 1, 1, 0, ID_ADD, 0, 0, 0);
        for (int i = 0; i < int'(MD_LAT) - 1; i++) begin
            cyc_chk("mul_wait", 0, 1, 1, 0, 1);
        end
        cyc_chk("mul_done", 1, 0, 0, 0, 0);
        set_in(0, 1, 3, 4, 21, 1, 1, 1, 0, ID_ADDW, 0, 0, 0);
        cyc_chk("addw_issue", 1, 0, 0, 0, 0);
        set_in(0, 1, 3, 4, 22, 1, 1, 1, 0, ID_SLLW, 0, 0, 0);
        cyc_chk("sllw_issue", 1, 0, 0, 0, 0);
        set_in(0, 1, 3, 4, 23, 1, 1, 1, 0, ID_REMUW, 0, 0, 0);
        cyc_chk("remuw_issue", 1, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        cyc_chk("remuw_busy", 0, 0, 1, 0, 1);
        set_in(0, 1, 3, 0, 24, 1, 0, 1, 0, ID_ADD, 1, 0, 0);
        cyc_chk("redir_in_wait", 0, 0, 1, 1, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        for (int i = 0; i < int'(MD_LAT) - 3; i++) begin
            cyc_chk("remuw_tail", 0, 0, 1, 0, 1);
        end
        cyc_chk("remuw_end", 0, 0, 1, 0, 0);

        // ---------- reset three cycles into a divide wait ----------
        set_in(0, 1, 1, 0, 15, 1, 0, 1, 0, ID_DIV, 0, 0, 0);
        cyc_chk("div_issue", 1, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc_chk("div_wait", 0, 0, 1, 0, 1);
        end
        set_in(1, 1, 15, 0, 16, 1, 0, 1, 0, ID_ADD, 0, 0, 0);
        cyc_chk("div_rst", 0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        chk32("div_rst.pending", dut.u_sb.r_pending, zero32);
        cyc_chk("after_rst", 0, 0, 1, 0, 0);
        set_in(0, 1, 15, 0, 16, 1, 0, 1, 0, ID_ADD, 0, 0, 0);
        cyc_chk("after_rst_issue", 1, 0, 0, 0, 0);

        // ---------- randomized traffic against the model ----------
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, ID_NOP, 0, 0, 0);
        @(posedge clk);
        model_update();
        #1;
        for (int n = 0; n < 2000; n++) begin
            bit ei, es, eb, ef, ebusy;
            logic [6:0] iid;
            if ($urandom_range(0, 5) == 0) iid = md_codes[$urandom_range(0, 12)];
            else                           iid = 7'($urandom_range(0, 7));
            set_in(($urandom_range(0, 63) == 0),
                   ($urandom_range(0, 3) != 0),
                   5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                   5'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), iid,
                   ($urandom_range(0, 7) == 0),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)));
            @(negedge clk);
            model_expect(ei, es, eb, ef, ebusy);
            chk_outs("rand", ei, es, eb, ef, ebusy);
            @(posedge clk);
            model_update();
            #1;
            chk32("rand.pending", dut.u_sb.r_pending, m_pend);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
